approx_mult_error_sweep: RTL and testbench
==========================================

# approx_mult_error_sweep

Sequential characterization engine for the team's approximate unsigned multipliers. It sits on both sides of a multiplier under test: it drives every operand pair into the multiplier's x/y inputs and consumes the returned product z. It compares each z against an internally computed exact product and accumulates error statistics: error count, sum of absolute error, maximum absolute error and signed error sum. It supports exhaustive on-chip or FPGA-side sweeps of any 8x8 variant without a simulator-side golden model.

## Interface
- WIDTH, 8: operand width; product width is 2*WIDTH; sweep length N = 2^(2*WIDTH).
- LATENCY, 0: clock cycles between operands on x_o/y_o and the matching product on z_i (0 = combinational multiplier).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when final statistics are valid.
- x_o  out  WIDTH  operand x to multiplier under test.
- y_o  out  WIDTH  operand y to multiplier under test.
- z_i  in  2*WIDTH  product returned by multiplier under test.
- err_count  out  2*WIDTH+1  number of pairs with z_i != x*y.
- sum_abs_err  out  4*WIDTH  sum of |z_i - x*y|.
- max_abs_err  out  2*WIDTH  maximum |z_i - x*y|.
- sum_signed_err  out  4*WIDTH+1  two's-complement sum of (z_i - x*y).

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start=1: clear all four accumulators, clear pair counter, go to SWEEP.
- SWEEP: counter n runs 0..N-1; x_o = n[WIDTH-1:0], y_o = n[2*WIDTH-1:WIDTH] (x varies fastest). After n = N-1, go to DRAIN (LATENCY>0) or directly DONE (LATENCY=0).
- DRAIN: LATENCY cycles; x_o/y_o = 0; outstanding products are still accumulated. Then DONE.
- DONE: done=1 for exactly one cycle, then IDLE. The accumulators hold their values until the next start.
- x_o/y_o = 0 in IDLE, DRAIN and DONE.
- Exact product and a valid bit travel through a LATENCY-deep delay line aligned with z_i. Only valid-tagged cycles update the accumulators.
- Error arithmetic: e = z_i - exact, signed 2*WIDTH+1 bits; a = |e|, fits 2*WIDTH bits.
  - err_count += (e != 0).
  - sum_abs_err += a; sum_signed_err += e.
  - max_abs_err = a if a > max_abs_err.
- The accumulators cannot overflow for a full sweep (N*(2^(2W)-1) < 2^(4W)).
- start while busy=1: ignored.
- start asserted in the same cycle as done: accepted; a new sweep begins next cycle.
- rst at any time: immediate return to IDLE, discard sweep.

## Timing
- Reset values: busy=0, done=0, x_o=0, y_o=0, all statistic outputs 0, state IDLE.
- Cycle numbering: cycle 0 is the first cycle after the edge that samples start=1.
- Pair n is on x_o/y_o during cycle n. z_i for pair n is sampled at the rising edge ending cycle n+LATENCY.
- busy=1 for cycles 0..N+LATENCY-1. done=1 in cycle N+LATENCY. The statistic outputs are final in that cycle.
- Statistic outputs are registered and update at most once per cycle. Each accumulation is visible the cycle after its sampling edge.
- Sweep throughput: one pair per cycle; no stalls.

## Test plan
- Reset: assert rst mid-sweep at pair 1000 -> same cycle busy=0, x_o=y_o=0, all stats 0. A later start restarts from n=0.
- Exact loopback, WIDTH=8, LATENCY=0 (z_i = x_o*y_o) -> err_count=0, sum_abs_err=0, max_abs_err=0, sum_signed_err=0, done in cycle 65536.
- Stuck-zero product (z_i=0) -> err_count=65025, sum_abs_err=1065369600, max_abs_err=65025, sum_signed_err=-1065369600.
- LSB forced high (z_i = (x*y)|1) -> err_count=49152, sum_abs_err=49152, max_abs_err=1, sum_signed_err=+49152.
- LATENCY=2 with a two-stage registered exact multiplier -> all stats 0 and done in cycle 65538. The same multiplier with LATENCY=0 configured -> err_count != 0.
- start pulsed during SWEEP -> ignored, done timing unchanged. A second start after done clears the stats and repeats the identical results.

Source files
------------

// File: rtl/approx_mult_error_sweep_if.sv
// Operand/product bus between the error-sweep engine
// and an approximate multiplier under test.
interface approx_mult_error_sweep_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   x_o;
  logic [WIDTH-1:0]   y_o;
  logic [2*WIDTH-1:0] z_i;

  modport master (output x_o, output y_o, input z_i);
  modport slave  (input x_o, input y_o, output z_i);
endinterface

// File: rtl/approx_mult_error_sweep.sv
// Exhaustive operand sweep engine that scores a multiplier
// under test against an exact product and accumulates error stats.
module approx_mult_error_sweep #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  approx_mult_error_sweep_if.master mul,
  output logic [2*WIDTH:0]     err_count,
  output logic [4*WIDTH-1:0]   sum_abs_err,
  output logic [2*WIDTH-1:0]   max_abs_err,
  output logic [4*WIDTH:0]     sum_signed_err
);
  localparam int PW = 2 * WIDTH;
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE, SWEEP, DRAIN, DONE
  } state_e;

  state_e state_q, state_d;
  logic [PW-1:0] n_q, n_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [PW:0]     cnt_q, cnt_d;
  logic [4*WIDTH-1:0] sabs_q, sabs_d;
  logic [PW-1:0]   mx_q, mx_d;
  logic [4*WIDTH:0] ssgn_q, ssgn_d;

  logic            go;
  logic            last_pair;
  logic            drain_end;
  logic [WIDTH-1:0] x_c, y_c;
  logic [PW-1:0]   exact_in, exact_o;
  logic            valid_in, valid_o;
  logic [PW:0]     e;
  logic [PW-1:0]   a;

  assign go        = start && (state_q == IDLE || state_q == DONE);
  assign last_pair = &n_q;
  assign drain_end = dcnt_q == DW'(LATENCY - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: if (last_pair)
               state_d = (LATENCY == 0) ? DONE : DRAIN;
      DRAIN: if (drain_end) state_d = DONE;
      DONE:  state_d = start ? SWEEP : IDLE;
    endcase
  end

  always_comb begin
    busy     = state_q == SWEEP || state_q == DRAIN;
    done     = state_q == DONE;
    valid_in = state_q == SWEEP;
    x_c      = '0;
    y_c      = '0;
    if (state_q == SWEEP) begin
      x_c = n_q[WIDTH-1:0];
      y_c = n_q[PW-1:WIDTH];
    end
  end

  assign mul.x_o  = x_c;
  assign mul.y_o  = y_c;
  assign exact_in = PW'(x_c) * PW'(y_c);

  always_comb begin
    n_d    = n_q;
    dcnt_d = '0;
    if (go)                    n_d = '0;
    else if (state_q == SWEEP) n_d = n_q + 1'b1;
    if (state_q == DRAIN)      dcnt_d = dcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q    <= '0;
      dcnt_q <= '0;
    end else begin
      n_q    <= n_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Exact product rides a delay line matched to the multiplier latency
  if (LATENCY == 0) begin : g_comb
    assign exact_o = exact_in;
    assign valid_o = valid_in;
  end else begin : g_pipe
    logic [PW-1:0]      ex_q [LATENCY];
    logic [PW-1:0]      ex_d [LATENCY];
    logic [LATENCY-1:0] v_q, v_d;

    always_comb begin
      ex_d[0] = exact_in;
      v_d[0]  = valid_in;
      for (int i = 1; i < LATENCY; i++) begin
        ex_d[i] = ex_q[i-1];
        v_d[i]  = v_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) ex_q[i] <= '0;
        v_q <= '0;
      end else begin
        for (int i = 0; i < LATENCY; i++) ex_q[i] <= ex_d[i];
        v_q <= v_d;
      end
    end

    assign exact_o = ex_q[LATENCY-1];
    assign valid_o = v_q[LATENCY-1];
  end

  assign e = {1'b0, mul.z_i} - {1'b0, exact_o};
  assign a = e[PW] ? (exact_o - mul.z_i) : (mul.z_i - exact_o);

  always_comb begin
    cnt_d  = cnt_q;
    sabs_d = sabs_q;
    mx_d   = mx_q;
    ssgn_d = ssgn_q;
    if (go) begin
      cnt_d  = '0;
      sabs_d = '0;
      mx_d   = '0;
      ssgn_d = '0;
    end else if (valid_o) begin
      cnt_d  = cnt_q + {{PW{1'b0}}, |e};
      sabs_d = sabs_q + {{PW{1'b0}}, a};
      ssgn_d = ssgn_q + {{PW{e[PW]}}, e};
      if (a > mx_q) mx_d = a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sabs_q <= '0;
      mx_q   <= '0;
      ssgn_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sabs_q <= sabs_d;
      mx_q   <= mx_d;
      ssgn_q <= ssgn_d;
    end
  end

  assign err_count      = cnt_q;
  assign sum_abs_err    = sabs_q;
  assign max_abs_err    = mx_q;
  assign sum_signed_err = ssgn_q;
endmodule

// File: tb/tb_approx_mult_error_sweep.sv
// Scoreboard bench: several sweep engines each paired with a
// different multiplier model, final stats checked on done.
module tb_approx_mult_error_sweep;
  logic clk = 1'b0;
  logic rst;
  logic start_b, start_s;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          done_cyc;
    logic [16:0] cnt;
    logic [31:0] sabs;
    logic [15:0] mx;
    logic [32:0] ssg;
    bit          nz_only;
  } exp_t;

  exp_t sb[6][$];

  logic        busy [6];
  logic        done [6];
  logic [16:0] cnt  [6];
  logic [31:0] sabs [6];
  logic [15:0] mx   [6];
  logic [32:0] ssg  [6];

  approx_mult_error_sweep_if #(.WIDTH(8)) m0 ();
  approx_mult_error_sweep_if #(.WIDTH(8)) m1 ();
  approx_mult_error_sweep_if #(.WIDTH(8)) m2 ();
  approx_mult_error_sweep_if #(.WIDTH(8)) m3 ();
  approx_mult_error_sweep_if #(.WIDTH(8)) m4 ();
  approx_mult_error_sweep_if #(.WIDTH(4)) ms ();

  logic [15:0] p0, p2, p3, p4;
  logic [15:0] r3a, r3b, r4a, r4b;
  assign p0 = {8'h0, m0.x_o} * {8'h0, m0.y_o};
  assign p2 = {8'h0, m2.x_o} * {8'h0, m2.y_o};
  assign p3 = {8'h0, m3.x_o} * {8'h0, m3.y_o};
  assign p4 = {8'h0, m4.x_o} * {8'h0, m4.y_o};
  always @(posedge clk) begin
    r3a <= p3; r3b <= r3a;
    r4a <= p4; r4b <= r4a;
  end
  assign m0.z_i = p0;
  assign m1.z_i = '0;
  assign m2.z_i = p2 | 16'd1;
  assign m3.z_i = r3b;
  assign m4.z_i = r4b;
  assign ms.z_i = '0;

  approx_mult_error_sweep #(.WIDTH(8), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy[0]),
    .done(done[0]), .mul(m0), .err_count(cnt[0]),
    .sum_abs_err(sabs[0]), .max_abs_err(mx[0]),
    .sum_signed_err(ssg[0]));
  approx_mult_error_sweep #(.WIDTH(8), .LATENCY(0)) u1 (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy[1]),
    .done(done[1]), .mul(m1), .err_count(cnt[1]),
    .sum_abs_err(sabs[1]), .max_abs_err(mx[1]),
    .sum_signed_err(ssg[1]));
  approx_mult_error_sweep #(.WIDTH(8), .LATENCY(0)) u2 (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy[2]),
    .done(done[2]), .mul(m2), .err_count(cnt[2]),
    .sum_abs_err(sabs[2]), .max_abs_err(mx[2]),
    .sum_signed_err(ssg[2]));
  approx_mult_error_sweep #(.WIDTH(8), .LATENCY(2)) u3 (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy[3]),
    .done(done[3]), .mul(m3), .err_count(cnt[3]),
    .sum_abs_err(sabs[3]), .max_abs_err(mx[3]),
    .sum_signed_err(ssg[3]));
  approx_mult_error_sweep #(.WIDTH(8), .LATENCY(0)) u4 (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy[4]),
    .done(done[4]), .mul(m4), .err_count(cnt[4]),
    .sum_abs_err(sabs[4]), .max_abs_err(mx[4]),
    .sum_signed_err(ssg[4]));

  logic [8:0]  cnt_s;
  logic [15:0] sabs_s;
  logic [7:0]  mx_s;
  logic [16:0] ssg_s;
  approx_mult_error_sweep #(.WIDTH(4), .LATENCY(0)) u5 (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy[5]),
    .done(done[5]), .mul(ms), .err_count(cnt_s),
    .sum_abs_err(sabs_s), .max_abs_err(mx_s),
    .sum_signed_err(ssg_s));
  assign cnt[5]  = {8'h0, cnt_s};
  assign sabs[5] = {16'h0, sabs_s};
  assign mx[5]   = {8'h0, mx_s};
  assign ssg[5]  = {{16{ssg_s[16]}}, ssg_s};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic push(input int i, input int dc,
                      input logic [16:0] c, input logic [31:0] s,
                      input logic [15:0] m, input logic [32:0] g,
                      input bit nz);
    exp_t x;
    x.done_cyc = dc;
    x.cnt = c; x.sabs = s; x.mx = m; x.ssg = g;
    x.nz_only = nz;
    sb[i].push_back(x);
  endtask

  // monitor: pops the scoreboard whenever an engine reports done
  exp_t ex;
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (done[i]) begin
        if (sb[i].size() == 0) begin
          total++; bad++;
          $display("FAIL d%0d_spurious_done got=1 want=0", i);
        end else begin
          ex = sb[i].pop_front();
          chk($sformatf("d%0d_done_cyc", i), 64'(cyc),
              64'(ex.done_cyc));
          if (ex.nz_only) begin
            chk($sformatf("d%0d_cnt_nonzero", i),
                64'(cnt[i] != 0), 64'd1);
          end else begin
            chk($sformatf("d%0d_cnt", i), 64'(cnt[i]), 64'(ex.cnt));
            chk($sformatf("d%0d_sabs", i), 64'(sabs[i]),
                64'(ex.sabs));
            chk($sformatf("d%0d_max", i), 64'(mx[i]), 64'(ex.mx));
            chk($sformatf("d%0d_ssg", i), 64'(ssg[i]), 64'(ex.ssg));
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain_sb(input int limit);
    int pend;
    while (cyc < limit) begin
      pend = 0;
      for (int i = 0; i < 6; i++) pend += sb[i].size();
      if (pend == 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      if (sb[i].size() != 0) begin
        total++; bad++;
        $display("FAIL d%0d_timeout pending=%0d need=0",
                 i, sb[i].size());
        sb[i].delete();
      end
    end
  endtask

  int c;
  int ds;

  initial begin
    rst = 1'b1; start_b = 1'b0; start_s = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy[1]), 64'd0);
    chk("rst_done", 64'(done[1]), 64'd0);
    chk("rst_x", 64'(m1.x_o), 64'd0);
    chk("rst_cnt", 64'(cnt[1]), 64'd0);
    chk("rst_ssg", 64'(ssg[5]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of a sweep, at pair 1000
    c = cyc; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("sw0_x", 64'(m0.x_o), 64'd0);
    wait_cyc(c + 1 + 1000);
    chk("p1000_x", 64'(m0.x_o), 64'd232);
    chk("p1000_y", 64'(m0.y_o), 64'd3);
    chk("p1000_cnt_nz", 64'(cnt[1] != 0), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy[1]), 64'd0);
    chk("mid_rst_x", 64'(m1.x_o), 64'd0);
    chk("mid_rst_y", 64'(m1.y_o), 64'd0);
    chk("mid_rst_cnt", 64'(cnt[1]), 64'd0);
    chk("mid_rst_sabs", 64'(sabs[1]), 64'd0);
    chk("mid_rst_max", 64'(mx[1]), 64'd0);
    chk("mid_rst_ssg", 64'(ssg[1]), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 4-bit stuck-zero engine: ignored start, restart in done cycle
    c = cyc; start_s = 1'b1;
    push(5, c + 1 + 256, 17'd225, 32'd14400, 16'd225, -33'sd14400, 0);
    @(negedge clk); start_s = 1'b0;
    wait_cyc(c + 1 + 100);
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    wait_cyc(c + 1 + 256);
    start_s = 1'b1;
    ds = cyc;
    push(5, ds + 1 + 256, 17'd225, 32'd14400, 16'd225, -33'sd14400, 0);
    @(negedge clk); start_s = 1'b0;
    wait_cyc(ds + 1 + 5);
    chk("restart_cnt_clr", 64'(cnt[5]), 64'd0);
    chk("restart_sabs_clr", 64'(sabs[5]), 64'd0);
    drain_sb(ds + 400);
    repeat (3) @(negedge clk);
    c = cyc; start_s = 1'b1;
    push(5, c + 1 + 256, 17'd225, 32'd14400, 16'd225, -33'sd14400, 0);
    @(negedge clk); start_s = 1'b0;
    drain_sb(c + 400);

    // full 8x8 sweeps on all five models in parallel
    c = cyc; start_b = 1'b1;
    push(0, c + 1 + 65536, 17'd0, 32'd0, 16'd0, 33'sd0, 0);
    push(1, c + 1 + 65536, 17'd65025, 32'd1065369600, 16'd65025,
         -33'sd1065369600, 0);
    push(2, c + 1 + 65536, 17'd49152, 32'd49152, 16'd1,
         33'sd49152, 0);
    push(3, c + 1 + 65538, 17'd0, 32'd0, 16'd0, 33'sd0, 0);
    push(4, c + 1 + 65536, 17'd0, 32'd0, 16'd0, 33'sd0, 1);
    @(negedge clk); start_b = 1'b0;
    chk("big_c0_x", 64'(m0.x_o), 64'd0);
    chk("big_c0_busy", 64'(busy[3]), 64'd1);
    @(negedge clk);
    chk("big_c1_x", 64'(m0.x_o), 64'd1);
    wait_cyc(c + 1 + 256);
    chk("big_c256_x", 64'(m0.x_o), 64'd0);
    chk("big_c256_y", 64'(m0.y_o), 64'd1);
    wait_cyc(c + 1 + 5000);
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    drain_sb(c + 70000);
    @(negedge clk);
    chk("end_busy", 64'(busy[3]), 64'd0);
    chk("end_x", 64'(m3.x_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
